// File: rtl/types_def.sv
// Shared types for the memory-controller back end.
//   data_width       : read/write data width
//   read_entries_log : read index width; ROB depth is 2**read_entries_log
//   r_type           : completion kind delivered by the burst handler
package types_def;

    localparam int data_width       = 16;
    localparam int read_entries_log = 6;

    typedef enum logic {
        read  = 1'b0,
        write = 1'b1
    } r_type;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer for read completions, indexed by read index.
// Holds one data word and one valid bit per index, releases entries strictly
// in index order starting from head, and tracks occupancy and collisions.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   st_valid       : store a read completion this cycle
//   st_index       : slot to store into
//   st_data        : data to store
//   rel_ready      : downstream register can take the head entry this cycle
//   head_vld       : slot at head holds data (release happens when rel_ready)
//   head_data      : data at head
//   head_index     : current head index
//   count          : number of occupied slots
//   collision_err  : sticky, a store hit an occupied slot
module reorder_buffer
    import types_def::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        st_valid,
    input  logic [read_entries_log-1:0] st_index,
    input  logic [data_width-1:0]       st_data,
    input  logic                        rel_ready,
    output logic                        head_vld,
    output logic [data_width-1:0]       head_data,
    output logic [read_entries_log-1:0] head_index,
    output logic [read_entries_log:0]   count,
    output logic                        collision_err
);

    localparam int IW    = read_entries_log;
    localparam int CW    = read_entries_log + 1;
    localparam int DEPTH = 2 ** read_entries_log;

    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [data_width-1:0] data_q [DEPTH];
    logic [IW-1:0]         head_q, head_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  coll_q, coll_d;

    logic release_en;
    logic store_ok;
    logic store_coll;

    // A store aimed at head in the same cycle head is released sees the slot
    // still valid, so it falls into the collision path automatically.
    always_comb begin
        release_en = vld_q[head_q] && rel_ready;
        store_coll = st_valid && vld_q[st_index];
        store_ok   = st_valid && !vld_q[st_index];

        vld_d = vld_q;
        if (release_en) begin
            vld_d[head_q] = 1'b0;
        end
        if (store_ok) begin
            vld_d[st_index] = 1'b1;
        end

        head_d = head_q;
        if (release_en) begin
            head_d = head_q + IW'(1);
        end

        count_d = count_q;
        if (store_ok && !release_en) begin
            count_d = count_q + CW'(1);
        end else if (!store_ok && release_en) begin
            count_d = count_q - CW'(1);
        end

        coll_d = coll_q | store_coll;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            head_q  <= '0;
            count_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            count_q <= count_d;
            coll_q  <= coll_d;
        end
    end

    // Data array is deliberately left unreset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            data_q[st_index] <= st_data;
        end
    end

    assign head_vld      = vld_q[head_q];
    assign head_data     = data_q[head_q];
    assign head_index    = head_q;
    assign count         = count_q;
    assign collision_err = coll_q;

endmodule

// File: rtl/returner.sv
// Final back-end stage of the memory controller.
// Write completions are acknowledged one cycle later; read completions are
// reordered through the ROB and returned in index order via a ready/valid
// output register. Input is never stalled.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   in_valid/in_type/in_data/in_index : completion from the burst handler
//   rd_valid/rd_ready/rd_data/rd_index : in-order read response
//   wr_ack_valid/wr_ack_index   : one-cycle write acknowledge
//   rob_count                   : occupied ROB slots
//   collision_err               : sticky read-slot collision flag
module returner
    import types_def::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  r_type                       in_type,
    input  logic [data_width-1:0]       in_data,
    input  logic [read_entries_log-1:0] in_index,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [data_width-1:0]       rd_data,
    output logic [read_entries_log-1:0] rd_index,
    output logic                        wr_ack_valid,
    output logic [read_entries_log-1:0] wr_ack_index,
    output logic [read_entries_log:0]   rob_count,
    output logic                        collision_err
);

    logic                        rd_valid_q, rd_valid_d;
    logic [data_width-1:0]       rd_data_q, rd_data_d;
    logic [read_entries_log-1:0] rd_index_q, rd_index_d;
    logic                        wr_ack_valid_q, wr_ack_valid_d;
    logic [read_entries_log-1:0] wr_ack_index_q, wr_ack_index_d;

    logic                        st_valid;
    logic                        rel_ready;
    logic                        head_vld;
    logic [data_width-1:0]       head_data;
    logic [read_entries_log-1:0] head_index;
    logic                        load;

    assign st_valid  = in_valid && (in_type == read);
    // Output register is free when empty or when its content leaves now.
    assign rel_ready = !rd_valid_q || rd_ready;
    assign load      = head_vld && rel_ready;

    reorder_buffer u_rob (
        .clk           (clk),
        .rst_n         (rst_n),
        .st_valid      (st_valid),
        .st_index      (in_index),
        .st_data       (in_data),
        .rel_ready     (rel_ready),
        .head_vld      (head_vld),
        .head_data     (head_data),
        .head_index    (head_index),
        .count         (rob_count),
        .collision_err (collision_err)
    );

    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_index_d = rd_index_q;
        if (load) begin
            rd_valid_d = 1'b1;
            rd_data_d  = head_data;
            rd_index_d = head_index;
        end else if (rd_ready) begin
            rd_valid_d = 1'b0;
        end

        wr_ack_valid_d = in_valid && (in_type == write);
        wr_ack_index_d = wr_ack_index_q;
        if (wr_ack_valid_d) begin
            wr_ack_index_d = in_index;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_index_q     <= '0;
            wr_ack_valid_q <= 1'b0;
            wr_ack_index_q <= '0;
        end else begin
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_index_q     <= rd_index_d;
            wr_ack_valid_q <= wr_ack_valid_d;
            wr_ack_index_q <= wr_ack_index_d;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_index     = rd_index_q;
    assign wr_ack_valid = wr_ack_valid_q;
    assign wr_ack_index = wr_ack_index_q;

endmodule

// File: tb/tb_returner.sv
// Bench for returner: directed scenarios plus randomized batches, checked
// against an in-order scoreboard (index/data per transfer), a write-ack
// expectation, a sticky collision model and output-hold rules.
module tb_returner;
    import types_def::*;

    localparam int IW    = read_entries_log;
    localparam int DW    = data_width;
    localparam int DEPTH = 2 ** read_entries_log;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    r_type         in_type;
    logic [DW-1:0] in_data;
    logic [IW-1:0] in_index;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [IW-1:0] rd_index;
    logic          wr_ack_valid;
    logic [IW-1:0] wr_ack_index;
    logic [IW:0]   rob_count;
    logic          collision_err;

    returner dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_type       (in_type),
        .in_data       (in_data),
        .in_index      (in_index),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_index      (rd_index),
        .wr_ack_valid  (wr_ack_valid),
        .wr_ack_index  (wr_ack_index),
        .rob_count     (rob_count),
        .collision_err (collision_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference: data per index, pending set, next index due out, sticky error.
    logic [DW-1:0] m_data [DEPTH];
    bit            m_pend [DEPTH];
    int            exp_next;
    bit            exp_coll;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
        exp_next = 0;
        exp_coll = 1'b0;
    endtask

    task automatic drive_rd(input int idx, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_type  = read;
        in_index = IW'(idx);
        in_data  = d;
    endtask

    task automatic drive_wr(input int idx);
        in_valid = 1'b1;
        in_type  = write;
        in_index = IW'(idx);
        in_data  = DW'($urandom);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    // One clock: score the pre-edge handshake and store, then check post-edge.
    task automatic cyc();
        bit            wexp;
        logic [IW-1:0] widx;
        bit            hold;
        logic [DW-1:0] hdata;
        logic [IW-1:0] hidx;
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            chk("xfer_index", 32'(rd_index), 32'(exp_next));
            chk("xfer_data", 32'(rd_data), 32'(m_data[exp_next]));
            m_pend[exp_next] = 1'b0;
            exp_next = (exp_next + 1) % DEPTH;
        end
        if (in_valid && in_type == read) begin
            if (m_pend[in_index]) begin
                exp_coll = 1'b1;
            end else begin
                m_pend[in_index] = 1'b1;
                m_data[in_index] = in_data;
            end
        end
        wexp  = in_valid && in_type == write;
        widx  = in_index;
        hold  = (rd_valid === 1'b1) && !rd_ready;
        hdata = rd_data;
        hidx  = rd_index;
        @(posedge clk);
        #1;
        chk("wr_ack_valid", 32'(wr_ack_valid), 32'(wexp));
        if (wexp) chk("wr_ack_index", 32'(wr_ack_index), 32'(widx));
        chk("collision_err", 32'(collision_err), 32'(exp_coll));
        if (hold) begin
            chk("hold_valid", 32'(rd_valid), 32'd1);
            chk("hold_index", 32'(rd_index), 32'(hidx));
            chk("hold_data", 32'(rd_data), 32'(hdata));
        end
    endtask

    task automatic drain(input int target, input int budget, input bit rnd);
        int n;
        n = 0;
        idle();
        while (exp_next != target && n < budget) begin
            rd_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            cyc();
            n++;
        end
        chk("drain_timeout", 32'(exp_next), 32'(target));
    endtask

    task automatic run_random(input int batches);
        int base;
        int k;
        int j;
        int t;
        int ord [8];
        for (int b = 0; b < batches; b++) begin
            base = exp_next;
            for (int i = 0; i < 8; i++) ord[i] = (base + i) % DEPTH;
            for (int i = 7; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            k = 0;
            while (k < 8) begin
                rd_ready = 1'($urandom_range(1, 0));
                if ($urandom_range(2, 0) != 0) begin
                    drive_rd(ord[k], DW'($urandom));
                    k++;
                end else if ($urandom_range(1, 0) == 1) begin
                    drive_wr(int'($urandom_range(DEPTH - 1, 0)));
                end else begin
                    idle();
                end
                cyc();
            end
            drain((base + 8) % DEPTH, 100, 1'b1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_rd_index"}, 32'(rd_index), 32'd0);
        chk({tag, "_wr_ack_valid"}, 32'(wr_ack_valid), 32'd0);
        chk({tag, "_wr_ack_index"}, 32'(wr_ack_index), 32'd0);
        chk({tag, "_rob_count"}, 32'(rob_count), 32'd0);
        chk({tag, "_collision"}, 32'(collision_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_type  = read;
        in_data  = '0;
        in_index = '0;
        rd_ready = 1'b0;
        model_reset();
        repeat (3) cyc();
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc();

        // Write acknowledge only, no read output.
        drive_wr(5);
        cyc();
        chk("wr_no_rd", 32'(rd_valid), 32'd0);
        idle();
        cyc();
        chk("wr_ack_gone", 32'(wr_ack_valid), 32'd0);

        // In-order reads 0,1,2.
        rd_ready = 1'b1;
        drive_rd(0, 16'h00A0); cyc();
        chk("io_lat", 32'(rd_valid), 32'd0);
        drive_rd(1, 16'h00A1); cyc();
        chk("io_v0", 32'(rd_valid), 32'd1);
        chk("io_i0", 32'(rd_index), 32'd0);
        chk("io_d0", 32'(rd_data), 32'h00A0);
        drive_rd(2, 16'h00A2); cyc();
        chk("io_v1", 32'(rd_valid), 32'd1);
        chk("io_d1", 32'(rd_data), 32'h00A1);
        idle(); cyc();
        chk("io_v2", 32'(rd_valid), 32'd1);
        chk("io_d2", 32'(rd_data), 32'h00A2);
        cyc();
        chk("io_end", 32'(rd_valid), 32'd0);

        // Out-of-order 5,3,4 with head at 3.
        drive_rd(5, 16'h0B05); cyc();
        chk("ooo_cnt1", 32'(rob_count), 32'd1);
        chk("ooo_held", 32'(rd_valid), 32'd0);
        drive_rd(3, 16'h0B03); cyc();
        chk("ooo_cnt2", 32'(rob_count), 32'd2);
        drive_rd(4, 16'h0B04); cyc();
        chk("ooo_cnt2b", 32'(rob_count), 32'd2);
        chk("ooo_i3", 32'(rd_index), 32'd3);
        idle(); cyc();
        chk("ooo_cnt1b", 32'(rob_count), 32'd1);
        chk("ooo_i4", 32'(rd_index), 32'd4);
        cyc();
        chk("ooo_cnt0", 32'(rob_count), 32'd0);
        chk("ooo_i5", 32'(rd_index), 32'd5);
        cyc();
        chk("ooo_end", 32'(rd_valid), 32'd0);

        // Backpressure on index 6, then 7 follows.
        rd_ready = 1'b0;
        drive_rd(6, 16'h0C06); cyc();
        drive_rd(7, 16'h0C07); cyc();
        idle();
        repeat (5) cyc();
        chk("bp_valid", 32'(rd_valid), 32'd1);
        chk("bp_index", 32'(rd_index), 32'd6);
        chk("bp_data", 32'(rd_data), 32'h0C06);
        chk("bp_cnt", 32'(rob_count), 32'd1);
        rd_ready = 1'b1;
        cyc();
        chk("bp_next_v", 32'(rd_valid), 32'd1);
        chk("bp_next_i", 32'(rd_index), 32'd7);
        cyc();
        chk("bp_end", 32'(rd_valid), 32'd0);

        // Streamed reads through the wrap 63 -> 0.
        for (int k = 0; k < 59; k++) begin
            drive_rd((8 + k) % DEPTH, DW'($urandom));
            cyc();
            if (k >= 2) chk("wrap_stream", 32'(rd_valid), 32'd1);
        end
        drain(3, 20, 1'b0);
        cyc();
        chk("wrap_idle", 32'(rd_valid), 32'd0);
        chk("wrap_cnt", 32'(rob_count), 32'd0);

        run_random(12);
        cyc();
        chk("rnd_cnt", 32'(rob_count), 32'd0);

        // Reset while a response is held and three slots are occupied.
        rd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_rd((exp_next + k) % DEPTH, DW'($urandom));
            cyc();
        end
        idle();
        chk("pre_rst_valid", 32'(rd_valid), 32'd1);
        chk("pre_rst_cnt", 32'(rob_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();
        rd_ready = 1'b1;
        drive_rd(1, 16'h00B1); cyc();
        drive_rd(0, 16'h00B0); cyc();
        idle();
        chk("post_rst_wait", 32'(rd_valid), 32'd0);
        cyc();
        chk("post_rst_i0", 32'(rd_index), 32'd0);
        chk("post_rst_d0", 32'(rd_data), 32'h00B0);
        cyc();
        chk("post_rst_i1", 32'(rd_index), 32'd1);
        cyc();
        chk("post_rst_end", 32'(rd_valid), 32'd0);

        // Collision on index 3; first data must survive.
        drive_rd(3, 16'h00C3); cyc();
        drive_rd(3, 16'h003C); cyc();
        chk("coll_flag", 32'(collision_err), 32'd1);
        chk("coll_cnt", 32'(rob_count), 32'd1);
        drive_rd(2, 16'h00C2); cyc();
        idle(); cyc();
        chk("coll_i2", 32'(rd_index), 32'd2);
        cyc();
        chk("coll_i3", 32'(rd_index), 32'd3);
        chk("coll_keep", 32'(rd_data), 32'h00C3);
        cyc();
        chk("coll_end", 32'(rd_valid), 32'd0);
        chk("coll_cnt0", 32'(rob_count), 32'd0);
        chk("coll_sticky", 32'(collision_err), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/returner.md
# returner

Final back-end stage of the memory controller. It consumes per-request completions from the burst handler, issues write acknowledgements immediately, and returns read data to the front end strictly in read-index order through a reorder buffer (ROB) indexed by the read index. The burst handler cannot be stalled, so the returner always accepts input.

## Interface
- `data_width`, default 16: read/write data width, from `types_def`.
- `read_entries_log`, default 6: read index width; the ROB holds `2**read_entries_log` entries.
- `clk` input, 1: the single clock; all state changes on its rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: completion present this cycle (burst handler `returner_valid`).
- `in_type` input, `r_type`: `read` or `write`.
- `in_data` input, `data_width`: read data; ignored for writes.
- `in_index` input, `read_entries_log`: request index.
- `rd_valid` output, 1: in-order read response valid.
- `rd_ready` input, 1: front end accepts the read response.
- `rd_data` output, `data_width`: read data.
- `rd_index` output, `read_entries_log`: index of the response; also tells the front end the index is free again.
- `wr_ack_valid` output, 1: one-cycle write acknowledge pulse.
- `wr_ack_index` output, `read_entries_log`: index of the acknowledged write.
- `rob_count` output, `read_entries_log+1`: number of occupied ROB slots.
- `collision_err` output, 1: sticky error, set when a read arrives for an already-occupied slot.

## Operation
- **Write path:** if `in_valid` and `in_type==write`, then on the next edge `wr_ack_valid` is 1 and `wr_ack_index` equals `in_index`. `wr_ack_valid` is 0 on every other cycle. There is no backpressure.
- **Read path, storing:** if `in_valid` and `in_type==read`, store `in_data` into `rob_data[in_index]` and set `rob_vld[in_index]`.
  - If that slot is already valid: drop the new data, keep the old data, and set `collision_err`.
- **Read path, head pointer:** `head`, `read_entries_log` bits, is the next index to release. It wraps modulo `2**read_entries_log`.
- **Read path, output register:** the output register loads when `rob_vld[head]` and (`!rd_valid` or `rd_ready`). On load:
  - `rd_data` takes `rob_data[head]` and `rd_index` takes `head`.
  - `rd_valid` is set to 1, `rob_vld[head]` is cleared, and `head` increments.
- **Read path, idle:** if `rd_ready` is high and nothing loads, `rd_valid` goes to 0.
- **Handshake rules:** a transfer occurs when `rd_valid && rd_ready`. While `rd_valid && !rd_ready`, `rd_data` and `rd_index` stay stable.
- **`rob_count`:** +1 on an accepted read store, −1 on an output load, unchanged when both happen in the same cycle. A dropped collision does not count.
- **Simultaneous events:**
  - A read write and a read release in the same cycle are both performed.
  - A store to slot `head` in the same cycle that the output register loads from `head` cannot occur legally. If it does, it is a collision: the store is dropped and the flag is set.
- **Reset (asynchronous, any time):** `head=0`, all `rob_vld=0`, `rd_valid=0`, `rd_data=0`, `rd_index=0`, `wr_ack_valid=0`, `wr_ack_index=0`, `rob_count=0`, `collision_err=0`. `rob_data` is not reset. An in-flight response is lost.

## Timing
- Write acknowledge latency is 1 cycle from `in_valid`.
- Read latency for the head index with the output register free: input at edge N sets the slot; `rd_valid` is high after edge N+1 (2 cycles).
- Sustained throughput is one read per cycle while `rd_ready=1` and consecutive indices are present.
- Out-of-order arrival (for example index 1 before index 0) is held until index 0 arrives. Both are then released on consecutive cycles.
- Wrap-around: after index `2**read_entries_log-1`, the next index released is 0.

## Structure
- `r_type`, `data_width` and `read_entries_log` come from the shared package `types_def`. No new package types are needed.
- One natural sub-module: `reorder_buffer`, containing the data array, valid bits, `head`, the count and the collision detect. The top level adds the write-acknowledge register and the output register.

## Test plan
- **Write acknowledge:** write with `in_index=5` at cycle 10 → `wr_ack_valid=1`, `wr_ack_index=5` in cycle 11 only; no read output.
- **In-order reads:** reads for indices 0,1,2 with data 0xA0,0xA1,0xA2 on consecutive cycles, `rd_ready=1` → `rd_valid` for 3 consecutive cycles starting 2 cycles after index 0; data 0xA0,0xA1,0xA2.
- **Out-of-order reads:** reads for indices 2,0,1 → outputs come out as indices 0,1,2 on consecutive cycles; `rob_count` peaks at 2 before draining to 0.
- **Backpressure:** index 0 is ready with `rd_ready=0` for 5 cycles → `rd_valid=1` with stable data and index; after `rd_ready=1`, index 1 follows on the next cycle.
- **Wrap and collision:**
  - Release indices 0..63 (with `read_entries_log=6`), then index 0 again → it is released.
  - Send index 3 twice without releasing it → `collision_err=1` and the first data is kept.
- **Reset mid-operation:** assert `rst_n=0` asynchronously while `rd_valid=1` and `rob_count=3` → all outputs are 0 immediately; after release, index 0 is expected next.
